// File: rtl/load_scoreboard_ctrl.sv
// Load scoreboard issue controller: tracks destination regs of in-flight loads and stalls decode
// on RAW/WAW hazards or a full load FIFO. Optional macro SCOREBOARD_BYPASS_EN enables writeback bypass.
module load_scoreboard_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int HANG_CYCLES     = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid_i,
    input  logic [4:0]                         id_rs1_i,
    input  logic [4:0]                         id_rs2_i,
    input  logic [4:0]                         id_rd_i,
    input  logic                               id_is_load_i,
    input  logic                               ex_ready_i,
    input  logic                               flush_i,
    input  logic                               ld_done_i,
    output logic [4:0]                         ld_done_rd_o,
    output logic                               issue_o,
    output logic                               stall_o,
    output logic [31:0]                        pending_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               hang_o,
    output logic                               ld_err_o
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HANG_CYCLES + 1);

    logic [4:0]    fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pend_q, pend_d, pend_eff;
    logic [HW-1:0] stall_cnt_q, stall_cnt_d;
    logic          hang_q, ld_err_q;

    logic          fifo_empty, fifo_full, full_eff;
    logic [4:0]    head_rd;
    logic          pop, push, haz;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign head_rd    = fifo_empty ? 5'd0 : fifo_q[rd_ptr_q];
    assign pop        = ld_done_i & ~fifo_empty;

`ifdef SCOREBOARD_BYPASS_EN
    // Returning load data is forwarded, so its reg and its FIFO slot are free this cycle.
    assign pend_eff = pend_q & ~(pop ? (32'd1 << head_rd) : 32'd0);
    assign full_eff = fifo_full & ~ld_done_i;
`else
    assign pend_eff = pend_q;
    assign full_eff = fifo_full;
`endif

    assign haz = ((id_rs1_i != 5'd0) & pend_eff[id_rs1_i])
               | ((id_rs2_i != 5'd0) & pend_eff[id_rs2_i])
               | ((id_rd_i  != 5'd0) & pend_eff[id_rd_i])
               | (id_is_load_i & full_eff);

    assign issue_o = id_valid_i & ~haz & ex_ready_i & ~flush_i;
    assign stall_o = id_valid_i & ~issue_o & ~flush_i;
    assign push    = issue_o & id_is_load_i;

    // Clear before set so a same-reg push/pop leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        if (pop) pend_d[head_rd] = 1'b0;
        if (push && id_rd_i != 5'd0) pend_d[id_rd_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        stall_cnt_d = '0;
        if (stall_o) begin
            stall_cnt_d = (stall_cnt_q == HW'(HANG_CYCLES)) ? stall_cnt_q : stall_cnt_q + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
            hang_q      <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q     <= count_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            hang_q      <= hang_q | (stall_cnt_d == HW'(HANG_CYCLES));
            ld_err_q    <= ld_err_q | (ld_done_i & fifo_empty);
        end
    end

    // Storage needs no reset: head is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= id_rd_i;
    end

    assign ld_done_rd_o  = head_rd;
    assign pending_o     = pend_q;
    assign outstanding_o = count_q;
    assign hang_o        = hang_q;
    assign ld_err_o      = ld_err_q;

endmodule

// File: tb/tb_load_scoreboard_ctrl.sv
// Testbench for load_scoreboard_ctrl: directed scenarios followed by random traffic, all checked
// against a queue-based model of outstanding loads.
module tb_load_scoreboard_ctrl;

  localparam int MAX  = 4;
  localparam int HANG = 8;

  logic clk = 1'b0;
  logic rst;
  logic id_valid_i, id_is_load_i, ex_ready_i, flush_i, ld_done_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [4:0] ld_done_rd_o;
  logic issue_o, stall_o, hang_o, ld_err_o;
  logic [31:0] pending_o;
  logic [$clog2(MAX):0] outstanding_o;

  int n_checks = 0;
  int n_fails  = 0;

  // model state: rds of outstanding loads, oldest first
  logic [4:0] exp_q[$];
  int m_stall_run = 0;
  bit m_hang = 0;
  bit m_err  = 0;

  load_scoreboard_ctrl #(.MAX_OUTSTANDING(MAX), .HANG_CYCLES(HANG)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_is_load_i(id_is_load_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .ld_done_i(ld_done_i), .ld_done_rd_o(ld_done_rd_o), .issue_o(issue_o), .stall_o(stall_o),
    .pending_o(pending_o), .outstanding_o(outstanding_o), .hang_o(hang_o), .ld_err_o(ld_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Register r is busy if any outstanding load targets it; with bypass the
  // returning oldest load no longer counts.
  function automatic bit busy(input logic [4:0] r, input bit skip_head);
    if (r == 5'd0) return 0;
    for (int i = (skip_head ? 1 : 0); i < exp_q.size(); i++)
      if (exp_q[i] == r) return 1;
    return 0;
  endfunction

  task automatic cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld, input logic rdy,
                       input logic fl, input logic done, input logic rs);
    bit skip, full, haz, e_issue, e_stall;
    logic [31:0] e_pend;
    @(negedge clk);
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd; id_is_load_i = ld;
    ex_ready_i = rdy; flush_i = fl; ld_done_i = done; rst = rs;
    #1;
`ifdef SCOREBOARD_BYPASS_EN
    skip = done && exp_q.size() != 0;
    full = (exp_q.size() == MAX) && !done;
`else
    skip = 0;
    full = (exp_q.size() == MAX);
`endif
    haz = busy(rs1, skip) || busy(rs2, skip) || busy(rd, skip) || (ld && full);
    e_issue = v && !haz && rdy && !fl;
    e_stall = v && !e_issue && !fl;
    e_pend = '0;
    foreach (exp_q[i]) if (exp_q[i] != 5'd0) e_pend[exp_q[i]] = 1'b1;
    check("issue", 32'(issue_o), 32'(e_issue));
    check("stall", 32'(stall_o), 32'(e_stall));
    check("pending", pending_o, e_pend);
    check("outstanding", 32'(outstanding_o), exp_q.size());
    check("ld_done_rd", 32'(ld_done_rd_o), exp_q.size() != 0 ? 32'(exp_q[0]) : 32'd0);
    check("hang", 32'(hang_o), 32'(m_hang));
    check("ld_err", 32'(ld_err_o), 32'(m_err));
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      m_stall_run = 0;
      m_hang = 0;
      m_err = 0;
    end else begin
      if (done && exp_q.size() != 0) void'(exp_q.pop_front());
      else if (done) m_err = 1;
      if (e_issue && ld) exp_q.push_back(rd);
      m_stall_run = e_stall ? ((m_stall_run < HANG) ? m_stall_run + 1 : HANG) : 0;
      if (m_stall_run >= HANG) m_hang = 1;
    end
  endtask

  task automatic idle(input logic done);
    cycle(0, 0, 0, 0, 0, 1, 0, done, 0);
  endtask

  initial begin
    rst = 1'b1;
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0; id_is_load_i = 0;
    ex_ready_i = 0; flush_i = 0; ld_done_i = 0;
    @(posedge clk);
    // reset state
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0);
    // RAW: lw x5 ; add x6,x5,x1
    cycle(1, 1, 0, 5, 1, 1, 0, 0, 0);
    repeat (3) cycle(1, 5, 1, 6, 0, 1, 0, 0, 0);
    cycle(1, 5, 1, 6, 0, 1, 0, 1, 0);
    cycle(1, 5, 1, 6, 0, 1, 0, 0, 0);
    idle(0);
    // full: four loads then a fifth that must wait for a completion
    for (int r = 1; r <= 4; r++) cycle(1, 0, 0, 5'(r), 1, 1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 7, 1, 1, 0, 0, 0);
    cycle(1, 0, 0, 7, 1, 1, 0, 1, 0);
    cycle(1, 0, 0, 7, 1, 1, 0, 0, 0);
    repeat (5) idle(1);
    // x0 load and WAW
    cycle(1, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle(1, 0, 0, 3, 1, 1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 3, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 3, 0, 1, 0, 1, 0);
    cycle(1, 0, 0, 3, 0, 1, 0, 1, 0);
    cycle(1, 0, 0, 3, 0, 1, 0, 0, 0);
    // flush of a stalled instruction, then completion with FIFO empty
    cycle(1, 0, 0, 9, 1, 1, 0, 0, 0);
    cycle(1, 9, 0, 10, 0, 1, 0, 0, 0);
    cycle(1, 9, 0, 10, 0, 1, 1, 0, 0);
    idle(1);
    idle(1);
    idle(0);
    // hang: long stall, hang is sticky until reset
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cycle(1, 0, 0, 5, 1, 1, 0, 0, 0);
    repeat (HANG + 1) cycle(1, 5, 0, 6, 0, 1, 0, 0, 0);
    idle(1);
    repeat (2) idle(0);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
